// File: rtl/dsp_pkg.sv
// dsp_pkg: shared definitions for the frame_buffer slice.
//   fb_state_t      - reader FSM state encoding (IDLE=0, PEND=1, WAIT_LO=2, BUSY=3)
//   XFER_ADDR_W_DEF - default width of the DMA word-index port
//   chans_legal()   - CHANS legality check (power of two, 2..256)
package dsp_pkg;

    localparam int unsigned XFER_ADDR_W_DEF = 16;
    localparam int unsigned CHANS_MIN       = 2;
    localparam int unsigned CHANS_MAX       = 256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_WAIT_LO = 2'd2,
        ST_BUSY    = 2'd3
    } fb_state_t;

    function automatic bit chans_legal(input int unsigned n);
        return (n >= CHANS_MIN) && (n <= CHANS_MAX) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// frame_bank_ram: two banks of CHANS words, register array.
//   wb_clk            - clock
//   we, wr_bank,
//   wr_idx, wr_data   - synchronous write port
//   rd_bank, rd_idx   - asynchronous read address
//   rd_data           - read data (combinational)
// Contents are not reset.
module frame_bank_ram #(
    parameter int unsigned CHANS  = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic                     wb_clk,
    input  logic                     we,
    input  logic                     wr_bank,
    input  logic [$clog2(CHANS)-1:0] wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_bank,
    input  logic [$clog2(CHANS)-1:0] rd_idx,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [2*CHANS];

    always_ff @(posedge wb_clk) begin
        if (we) begin
            mem[{wr_bank, wr_idx}] <= wr_data;
        end
    end

    assign rd_data = mem[{rd_bank, rd_idx}];

endmodule

// File: rtl/frame_buffer.sv
// frame_buffer: double-buffered sample frame store feeding the DMA.
// Collects CHANS samples into the writer bank; a completed frame is handed
// to the reader side (xfer_block pulse) and served by xfer_re/xfer_adr/xfer_dat.
//   wb_clk, wb_rst_n                 - clock, synchronous active-low reset
//   in_valid, in_first, in_data      - sample stream (in_first resyncs to index 0)
//   xfer_block                       - one-cycle frame-ready pulse
//   block_done, xfer_done            - DMA status inputs
//   xfer_re, xfer_adr, xfer_dat      - zero-latency read port of the reader bank
//   overflow, clr_ovf                - sticky dropped-frame flag and its clear
//   drop_count                       - dropped-frame counter, only when
//                                      FRAME_BUFFER_DROP_COUNT_EN is defined
module frame_buffer
    import dsp_pkg::*;
#(
    parameter int unsigned CHANS       = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned XFER_ADDR_W = XFER_ADDR_W_DEF
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst_n,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   xfer_block,
    input  logic                   block_done,
    input  logic                   xfer_done,
    input  logic                   xfer_re,
    input  logic [XFER_ADDR_W-1:0] xfer_adr,
    output logic [DATA_W-1:0]      xfer_dat,
    output logic                   overflow,
`ifdef FRAME_BUFFER_DROP_COUNT_EN
    output logic [15:0]            drop_count,
`endif
    input  logic                   clr_ovf
);

    localparam int unsigned IDX_W = $clog2(CHANS);

    if (!chans_legal(CHANS)) begin : g_bad_chans
        $error("frame_buffer: CHANS must be a power of two in 2..256");
    end

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] wr_pos;
    logic             wr_bank;
    logic             swap_q;
    logic             frame_cmpl;
    logic             reader_free;
    logic             take_frame;
    logic             drop_frame;
    fb_state_t        state;
    fb_state_t        state_nxt;
    logic             xfer_block_nxt;
    logic             adr_in_range;
    logic [DATA_W-1:0] rd_word;

    // Write pointer / completion detection
    assign wr_pos     = in_first ? '0 : wr_idx;
    assign frame_cmpl = in_valid && (wr_pos == IDX_W'(CHANS - 1));

    // The bank swap is decided at the completing write so the next sample
    // already lands in the fresh bank; swap_q then moves the FSM to PEND one
    // cycle later. swap_q also blocks a second swap before PEND is reached.
    assign reader_free = ((state == ST_IDLE) && !swap_q) ||
                         ((state == ST_BUSY) && block_done);
    assign take_frame  = frame_cmpl && reader_free;
    assign drop_frame  = frame_cmpl && !reader_free;

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            wr_idx     <= '0;
            wr_bank    <= 1'b0;
            swap_q     <= 1'b0;
            state      <= ST_IDLE;
            xfer_block <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (in_valid) begin
                wr_idx <= wr_pos + IDX_W'(1);
            end
            if (take_frame) begin
                wr_bank <= ~wr_bank;
            end
            swap_q     <= take_frame;
            state      <= state_nxt;
            xfer_block <= xfer_block_nxt;
            if (drop_frame) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Reader FSM next state
    always_comb begin
        state_nxt      = state;
        xfer_block_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (swap_q) begin
                    state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (xfer_done) begin
                    state_nxt = ST_IDLE;
                end else if (block_done) begin
                    state_nxt      = ST_WAIT_LO;
                    xfer_block_nxt = 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (xfer_done) begin
                    state_nxt = ST_IDLE;
                end else if (!block_done) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (block_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef FRAME_BUFFER_DROP_COUNT_EN
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            drop_count <= '0;
        end else if (drop_frame) begin
            if (clr_ovf) begin
                drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (clr_ovf) begin
            drop_count <= '0;
        end
    end
`endif

    frame_bank_ram #(
        .CHANS  (CHANS),
        .DATA_W (DATA_W)
    ) u_ram (
        .wb_clk  (wb_clk),
        .we      (in_valid),
        .wr_bank (wr_bank),
        .wr_idx  (wr_pos),
        .wr_data (in_data),
        .rd_bank (~wr_bank),
        .rd_idx  (xfer_adr[IDX_W-1:0]),
        .rd_data (rd_word)
    );

    // Out-of-range addresses and idle reads return zero
    assign adr_in_range = ((xfer_adr >> IDX_W) == '0);
    assign xfer_dat     = (xfer_re && adr_in_range) ? rd_word : '0;

endmodule

// File: tb/tb_frame_buffer.sv
module tb_frame_buffer;

    localparam int CHANS = 16;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic [15:0] in_data = '0;
    logic        xfer_block;
    logic        block_done;
    logic        man_bd = 1'b1;
    logic        dma_bd = 1'b1;
    logic        dma_auto = 1'b0;
    logic        xfer_done = 1'b0;
    logic        xfer_re = 1'b0;
    logic [15:0] xfer_adr = '0;
    logic [15:0] xfer_dat;
    logic        overflow;
    logic        clr_ovf = 1'b0;
`ifdef FRAME_BUFFER_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    assign block_done = dma_auto ? dma_bd : man_bd;

    always #5 wb_clk = ~wb_clk;

    frame_buffer #(
        .CHANS       (CHANS),
        .DATA_W      (16),
        .XFER_ADDR_W (16)
    ) dut (
        .wb_clk     (wb_clk),
        .wb_rst_n   (wb_rst_n),
        .in_valid   (in_valid),
        .in_first   (in_first),
        .in_data    (in_data),
        .xfer_block (xfer_block),
        .block_done (block_done),
        .xfer_done  (xfer_done),
        .xfer_re    (xfer_re),
        .xfer_adr   (xfer_adr),
        .xfer_dat   (xfer_dat),
        .overflow   (overflow),
`ifdef FRAME_BUFFER_DROP_COUNT_EN
        .drop_count (drop_count),
`endif
        .clr_ovf    (clr_ovf)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int n_pulse = 0;
    bit chk_en = 0;
    bit sweep = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Reader side described as an ownership phase of the completed bank:
    // 0 = reader bank free, 1 = frame announced but not yet offered to DMA,
    // 2 = offered, waiting for DMA to start, 3 = DMA working on it.
    logic [15:0] m_mem [2][CHANS];
    bit          m_known [2][CHANS];
    int          m_wb = 0, m_idx = 0, m_phase = 0;
    bit          m_handed = 0;
    bit          exp_blk = 0, exp_ovf = 0;
    int          exp_drops = 0;
    int          m_pos;
    bit          m_full, m_free;

    always @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            m_wb = 0; m_idx = 0; m_phase = 0; m_handed = 0;
            exp_blk = 0; exp_ovf = 0; exp_drops = 0;
        end else begin
            m_pos  = in_first ? 0 : m_idx;
            m_full = in_valid && (m_pos == CHANS - 1);
            m_free = (m_phase == 0 && !m_handed) || (m_phase == 3 && block_done);
            if (in_valid) begin
                m_mem[m_wb][m_pos]   = in_data;
                m_known[m_wb][m_pos] = 1;
                m_idx = (m_pos + 1) % CHANS;
            end
            exp_blk = 0;
            if (m_phase == 0 && m_handed) m_phase = 1;
            else if (m_phase == 1 && xfer_done) m_phase = 0;
            else if (m_phase == 1 && block_done) begin m_phase = 2; exp_blk = 1; end
            else if (m_phase == 2 && xfer_done) m_phase = 0;
            else if (m_phase == 2 && !block_done) m_phase = 3;
            else if (m_phase == 3 && block_done) m_phase = 0;
            m_handed = 0;
            if (m_full && m_free) begin
                m_wb = 1 - m_wb;
                m_handed = 1;
            end
            if (m_full && !m_free) begin
                exp_ovf = 1;
                exp_drops = clr_ovf ? 1 : (exp_drops < 65535 ? exp_drops + 1 : 65535);
            end else if (clr_ovf) begin
                exp_ovf = 0;
                exp_drops = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    int rb, ra;
    always @(negedge wb_clk) begin
        if (chk_en) begin
            check("xfer_block", xfer_block, exp_blk);
            check("overflow", overflow, exp_ovf);
`ifdef FRAME_BUFFER_DROP_COUNT_EN
            check("drop_count", drop_count, exp_drops);
`endif
            rb = 1 - m_wb;
            ra = xfer_adr;
            if (!xfer_re || ra >= CHANS) check("xfer_dat_zero", xfer_dat, 0);
            else if (m_known[rb][ra]) check("xfer_dat", xfer_dat, m_mem[rb][ra]);
            if (xfer_block) n_pulse++;
        end
    end

    // ---------------- DMA responder ----------------
    int dma_cnt = 0;
    always @(negedge wb_clk) begin
        if (dma_cnt > 0) begin
            dma_cnt--;
            if (dma_cnt == 0) dma_bd = 1'b1;
        end else if (dma_auto && xfer_block) begin
            dma_bd  = 1'b0;
            dma_cnt = 16;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge wb_clk);
        #1;
        if (sweep) xfer_adr = 16'((xfer_adr + 16'd1) % 16'd20);
    endtask

    task automatic send(input logic [15:0] d, input logic first);
        in_valid = 1'b1;
        in_first = first;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic peek(input logic [15:0] adr, input logic [15:0] exp, input string name);
        xfer_re  = 1'b1;
        xfer_adr = adr;
        #1;
        check(name, xfer_dat, exp);
        xfer_re  = 1'b0;
        xfer_adr = '0;
        #1;
    endtask

    int p0;

    initial begin
        tick(); tick();
        wb_rst_n = 1'b1;
        chk_en = 1;
        @(negedge wb_clk);
        check("rst_blk", xfer_block, 0);
        check("rst_ovf", overflow, 0);
        check("rst_dat", xfer_dat, 0);

        // 1: first frame, pulse two cycles after the completing write
        for (int i = 0; i < 16; i++) send(16'(i + 1), i == 0);
        @(negedge wb_clk); check("t1_blk_c0", xfer_block, 0);
        @(negedge wb_clk); check("t1_blk_c1", xfer_block, 0);
        @(negedge wb_clk); check("t1_blk_c2", xfer_block, 1);
        #1;
        peek(16'd5, 16'h0006, "t1_rd5");
        peek(16'd15, 16'h0010, "t1_rd15");
        peek(16'd20, 16'h0000, "t1_rd_oob");
        tick(); man_bd = 1'b0; tick(); man_bd = 1'b1; tick(); tick();

        // 2: three frames under the DMA responder, reads sweeping
        dma_auto = 1'b1; sweep = 1; xfer_re = 1'b1;
        p0 = n_pulse;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 16; i++) begin
                send(16'(16'h0100 * (f + 1) + i), i == 0);
                tick();
            end
        repeat (40) tick();
        check("t2_pulses", n_pulse - p0, 3);
        check("t2_ovf", overflow, 0);
        sweep = 0; xfer_re = 1'b0; xfer_adr = '0; dma_auto = 1'b0;
        tick();

        // 3: reader busy, second frame is dropped
        p0 = n_pulse;
        for (int i = 0; i < 16; i++) send(16'(16'h0300 + i), i == 0);
        tick(); tick();
        man_bd = 1'b0;
        for (int i = 0; i < 16; i++) send(16'(16'h0380 + i), i == 0);
        tick(); tick();
        @(negedge wb_clk);
        check("t3_ovf_set", overflow, 1);
        check("t3_pulses", n_pulse - p0, 1);
`ifdef FRAME_BUFFER_DROP_COUNT_EN
        check("t3_drops", drop_count, 1);
`endif
        #1;
        peek(16'd3, 16'h0303, "t3_rd_kept");
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        @(negedge wb_clk);
        check("t3_ovf_clr", overflow, 0);

        // 4: xfer_done while pending abandons the frame
        man_bd = 1'b1; tick(); tick();
        man_bd = 1'b0;
        p0 = n_pulse;
        for (int i = 0; i < 16; i++) send(16'(16'h0400 + i), i == 0);
        tick(); tick(); tick();
        xfer_done = 1'b1; tick(); xfer_done = 1'b0;
        man_bd = 1'b1;
        repeat (4) tick();
        check("t4_pulses", n_pulse - p0, 0);
        check("t4_ovf", overflow, 0);

        // 5: resync at index 7
        p0 = n_pulse;
        for (int i = 0; i < 7; i++) send(16'(16'h0500 + i), i == 0);
        send(16'h05AA, 1'b1);
        for (int k = 1; k < 15; k++) send(16'(16'h0510 + k), 1'b0);
        repeat (3) tick();
        check("t5_early", n_pulse - p0, 0);
        send(16'h051F, 1'b0);
        repeat (3) tick();
        check("t5_pulse", n_pulse - p0, 1);
        @(negedge wb_clk); #1;
        peek(16'd0, 16'h05AA, "t5_rd0");
        peek(16'd6, 16'h0516, "t5_rd6");
        peek(16'd15, 16'h051F, "t5_rd15");
        man_bd = 1'b0; tick(); man_bd = 1'b1; tick(); tick();

        // 6: reset mid-frame and during BUSY
        for (int i = 0; i < 5; i++) send(16'(16'h0600 + i), i == 0);
        wb_rst_n = 1'b0; tick(); wb_rst_n = 1'b1;
        @(negedge wb_clk);
        check("t6_rst1_blk", xfer_block, 0);
        check("t6_rst1_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) send(16'(16'h0700 + i), i == 0);
        tick(); tick();
        man_bd = 1'b0; tick(); tick();
        for (int i = 0; i < 16; i++) send(16'(16'h0800 + i), i == 0);
        tick();
        check("t6_ovf_before", overflow, 1);
        wb_rst_n = 1'b0; tick(); wb_rst_n = 1'b1;
        @(negedge wb_clk);
        check("t6_rst2_blk", xfer_block, 0);
        check("t6_rst2_ovf", overflow, 0);
        check("t6_rst2_dat", xfer_dat, 0);
        man_bd = 1'b1;
        p0 = n_pulse;
        repeat (5) tick();
        check("t6_no_stale", n_pulse - p0, 0);
        for (int i = 0; i < 16; i++) send(16'(16'h0900 + i), i == 0);
        repeat (6) tick();
        check("t6_one_pulse", n_pulse - p0, 1);

        tick();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/frame_buffer.md
# frame_buffer

Double-buffered sample frame store that sits directly upstream of the DMA block. It collects a serial stream of `DATA_W`-bit samples into a frame of `CHANS` words. Once a frame is complete, it hands the frame to the DMA by pulsing `xfer_block`, then serves the DMA's random-access reads through the `xfer_re`/`xfer_adr`/`xfer_dat` port. Capture continues into the other bank while the DMA drains the completed one.

## Interface
- `CHANS`, 16 — words per frame; power of two, 2..256
- `DATA_W`, 16 — sample and `xfer_dat` width
- `XFER_ADDR_W`, 16 — width of `xfer_adr`
- `wb_clk` in 1 — system clock
- `wb_rst_n` in 1 — one clock; reset is synchronous and active-low
- `in_valid` in 1 — sample strobe
- `in_first` in 1 — qualifies `in_valid`; the sample is channel 0 of a frame
- `in_data` in `DATA_W` — sample value
- `xfer_block` out 1 — one-cycle frame-ready pulse to the DMA
- `block_done` in 1 — from the DMA; high when idle or the block is written
- `xfer_done` in 1 — from the DMA; high when the DMA is stopped or finished
- `xfer_re` in 1 — DMA read enable
- `xfer_adr` in `XFER_ADDR_W` — DMA word index
- `xfer_dat` out `DATA_W` — read data
- `overflow` out 1 — sticky; a frame was dropped because the reader was busy
- `clr_ovf` in 1 — clears `overflow`

## Operation
- Storage: two banks of `CHANS` words. The writer owns `wr_bank`; the reader owns `!wr_bank`.
- Write path:
  - `in_valid` writes `in_data` to `wr_bank[wr_idx]`, then increments `wr_idx`.
  - `in_valid & in_first` forces the write to index 0 (resync); `wr_idx` becomes 1.
- Completion: a write at index `CHANS-1`. `wr_idx` wraps to 0.
- Reader FSM states: IDLE, PEND, WAIT_LO, BUSY.
- On completion, with the FSM in IDLE (or releasing this cycle):
  - Toggle `wr_bank`.
  - Go to PEND.
- On completion otherwise (PEND, WAIT_LO, BUSY):
  - The frame is dropped; the writer reuses the same bank.
  - `overflow` is set.
- PEND:
  - If `xfer_done` is high: go to IDLE, bank discarded, no overflow.
  - Else if `block_done` is high: assert `xfer_block` next cycle, go to WAIT_LO.
- WAIT_LO:
  - If `xfer_done` is high: go to IDLE (the DMA ignored the pulse).
  - Else if `block_done` is low: go to BUSY.
- BUSY: when `block_done` is high, release the bank and go to IDLE.
- Read port:
  - `xfer_dat = xfer_re ? bank[!wr_bank][xfer_adr] : 0`, combinational.
  - `xfer_adr >= CHANS` returns 0.
  - `xfer_dat` is never non-zero while `xfer_re` is low.
- `clr_ovf` clears `overflow`; if a set and a clear occur in the same cycle, set wins.

## Timing
- Reset (`wb_rst_n` low at a `wb_clk` edge):
  - `xfer_block` = 0, `overflow` = 0.
  - `wr_bank` = 0, `wr_idx` = 0, FSM = IDLE.
  - Memory contents are undefined. `xfer_dat` = 0 because it is gated by `xfer_re`.
- Reset mid-frame: the partial frame and any pending frame are discarded. No `xfer_block` is issued after reset deasserts until a new complete frame arrives.
- Latency: completing write at edge N; FSM = PEND after N+1; `xfer_block` high for the cycle after N+2 (if `block_done` is high and `xfer_done` is low).
- `xfer_block` is exactly one cycle wide and is never asserted outside the PEND→WAIT_LO transition.
- BUSY→IDLE release and a new completion in the same cycle: the new frame swaps, FSM goes to PEND, no overflow.
- Read data is valid in the same cycle as `xfer_re`/`xfer_adr` (zero latency).
- The writer bank is never readable; the reader bank is never written.

## Configuration
- `FRAME_BUFFER_DROP_COUNT_EN`
- Defined:
  - Adds output `drop_count` [15:0].
  - It increments on each overflow drop, saturates at 16'hFFFF, and is cleared by `clr_ovf` and by reset.
  - Set beats clear in the same cycle (count becomes 1).
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- `dsp_pkg` holds:
  - the FSM state encoding (IDLE=0, PEND=1, WAIT_LO=2, BUSY=3);
  - the `CHANS` legality check constant;
  - the shared `XFER_ADDR_W` default.
- Sub-module `frame_bank_ram`: dual-bank register array with a synchronous write port (bank, index) and an asynchronous read port (bank, index).
- `frame_buffer` holds the write pointer, FSM, overflow and drop logic.

## Test plan
- Reset, then 16 `in_valid` samples 0x0001..0x0010 with `in_first` on the first, `block_done`=1 → `xfer_block` high 2 cycles after the 16th write; with `xfer_re`=1, `xfer_adr`=5 → `xfer_dat`=0x0006.
- DMA model drops `block_done` 1 cycle after `xfer_block` and raises it 16 cycles later; stream 3 back-to-back frames → 3 `xfer_block` pulses, `overflow`=0.
- Hold `block_done` low after the first pulse and complete a second frame → `overflow`=1, no second pulse; `clr_ovf` → 0; with the macro, `drop_count`=1.
- `xfer_done`=1 while PEND → FSM returns to IDLE, no `xfer_block`, `overflow`=0.
- `in_first` at `wr_idx`=7 → the write lands at index 0, and completion occurs 15 samples later.
- Assert `wb_rst_n` low mid-frame and during BUSY → all outputs 0; next complete frame → a single `xfer_block`; `xfer_re`=0 → `xfer_dat`=0 throughout.
